// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared encodings for the MOV/MOC memory handshake (data type,
//               read/write, responder state) plus lane-mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam logic [1:0] DT_BYTE = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_WORD = 2'b10;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } resp_state_t;

  // Lane 0 is the byte at the request address; 2'b11 behaves as a word.
  function automatic logic [3:0] lane_mask(input logic [1:0] dt);
    case (dt)
      DT_BYTE: lane_mask = 4'b0001;
      DT_HALF: lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_if
// Description : MOV/MOC request/acknowledge bundle between initiator and
//               memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
  logic        MOV;
  logic        R_W;
  logic [1:0]  DT;
  logic [7:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        MOC;

  modport master (
    output MOV, R_W, DT, address, data_in,
    input  data_out, MOC
  );

  modport slave (
    input  MOV, R_W, DT, address, data_in,
    output data_out, MOC
  );
endinterface
`default_nettype wire

// File: rtl/mem_responder_byte_lane_array.sv
`default_nettype none
// ============================================================================
// Module      : byte_lane_array
// Description : 256x8 store with four byte-address lanes, per-lane write
//               enable, synchronous write and asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_array (
  input  logic            clk,
  input  logic [3:0]      we,
  input  logic [3:0][7:0] addr,
  input  logic [3:0][7:0] wdata,
  output logic [3:0][7:0] rdata
);

  logic [7:0] r_mem [256];

  // Lane addresses are consecutive mod 256, so lanes never collide.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        r_mem[addr[i]] <= wdata[i];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_rd_lane
    assign rdata[g] = r_mem[addr[g]];
  end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Big-endian 256-byte memory answering the MOV/MOC four-phase
//               handshake with WAIT_CYCLES wait states per access.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           clr,
  mem_responder_if.slave bus
);

  localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES);

  resp_state_t r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_addr, w_addr_nxt;
  logic        r_rw, w_rw_nxt;
  logic [1:0]  r_dt, w_dt_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic        r_moc, w_moc_nxt;
  logic [31:0] r_rdata, w_rdata_nxt;
  logic        w_access;

  logic [3:0]      w_we;
  logic [3:0][7:0] w_lane_addr;
  logic [3:0][7:0] w_lane_wdata;
  logic [3:0][7:0] w_lane_rdata;
  logic [31:0]     w_rd_packed;

  for (genvar g = 0; g < 4; g++) begin : g_lane_addr
    assign w_lane_addr[g] = r_addr + 8'(g);
  end

  // Big-endian steering: lane 0 always carries the most-significant byte.
  always_comb begin
    w_lane_wdata = '0;
    w_rd_packed  = '0;
    case (r_dt)
      DT_BYTE: begin
        w_lane_wdata[0] = r_wdata[7:0];
        w_rd_packed     = {24'h0, w_lane_rdata[0]};
      end
      DT_HALF: begin
        w_lane_wdata[0] = r_wdata[15:8];
        w_lane_wdata[1] = r_wdata[7:0];
        w_rd_packed     = {16'h0, w_lane_rdata[0], w_lane_rdata[1]};
      end
      default: begin
        w_lane_wdata[0] = r_wdata[31:24];
        w_lane_wdata[1] = r_wdata[23:16];
        w_lane_wdata[2] = r_wdata[15:8];
        w_lane_wdata[3] = r_wdata[7:0];
        w_rd_packed     = {w_lane_rdata[0], w_lane_rdata[1],
                           w_lane_rdata[2], w_lane_rdata[3]};
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_rw_nxt    = r_rw;
    w_dt_nxt    = r_dt;
    w_wdata_nxt = r_wdata;
    w_moc_nxt   = r_moc;
    w_rdata_nxt = r_rdata;
    w_access    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.MOV) begin
          w_addr_nxt  = bus.address;
          w_rw_nxt    = bus.R_W;
          w_dt_nxt    = bus.DT;
          w_wdata_nxt = bus.data_in;
          w_cnt_nxt   = c_wait_load;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!bus.MOV) begin
          w_state_nxt = IDLE;
        end else if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_access    = 1'b1;
          w_moc_nxt   = 1'b1;
          w_state_nxt = DONE;
          if (r_rw == RW_READ) begin
            w_rdata_nxt = w_rd_packed;
          end
        end
      end
      DONE: begin
        if (!bus.MOV) begin
          w_moc_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_moc_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Gating with clr keeps a reset in BUSY from committing the pending write.
  assign w_we = (w_access && (r_rw == RW_WRITE) && !clr) ? lane_mask(r_dt) : 4'b0000;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 8'd0;
      r_rw    <= RW_READ;
      r_dt    <= DT_BYTE;
      r_wdata <= 32'd0;
      r_moc   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_rw    <= w_rw_nxt;
      r_dt    <= w_dt_nxt;
      r_wdata <= w_wdata_nxt;
      r_moc   <= w_moc_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  byte_lane_array u_lanes (
    .clk   (clk),
    .we    (w_we),
    .addr  (w_lane_addr),
    .wdata (w_lane_wdata),
    .rdata (w_lane_rdata)
  );

  assign bus.MOC      = r_moc;
  assign bus.data_out = r_rdata;

endmodule
`default_nettype wire
